// File: rtl/inst_fetch.sv
// Instruction fetch: PC, optional direct-mapped I-cache, miss handling, one-entry output buffer.
// Define ICACHE_EN to build the cache; without it every fetch goes to memory.
module inst_fetch #(
    parameter int ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        iJUMP_en,
    input  logic [31:0] iJUMP_pc,
    input  logic        iIQ_full,
    output logic        oIQ_en,
    output logic [31:0] oIQ_inst,
    output logic [31:0] oIQ_pc,
    output logic        oMC_en,
    output logic [31:0] oMC_addr,
    input  logic        iMC_done,
    input  logic [31:0] iMC_inst
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] miss_q, miss_d;
    logic        pv_q, pv_d;
    logic [31:0] pinst_q, pinst_d;
    logic [31:0] ppc_q, ppc_d;
    logic        mce_q, mce_d;
    logic [31:0] mca_q, mca_d;

    logic        hit;
    logic [31:0] hit_data;
    logic        slot_free;

    assign oIQ_en    = rdy & pv_q & ~iIQ_full & ~iJUMP_en;
    assign oIQ_inst  = oIQ_en ? pinst_q : 32'h0;
    assign oIQ_pc    = oIQ_en ? ppc_q : 32'h0;
    assign oMC_en    = mce_q;
    assign oMC_addr  = mca_q;
    assign slot_free = ~pv_q | oIQ_en;

`ifdef ICACHE_EN
    localparam int IDX = $clog2(ICACHE_LINES);
    localparam int TW  = 30 - IDX;

    logic [ICACHE_LINES-1:0] valid_q;
    logic [TW-1:0]           tag_q  [ICACHE_LINES];
    logic [31:0]             data_q [ICACHE_LINES];
    logic [IDX-1:0]          ridx;
    logic [IDX-1:0]          widx;
    logic                    cwe;

    assign ridx     = pc_q[IDX+1:2];
    assign widx     = miss_q[IDX+1:2];
    assign hit      = valid_q[ridx] && (tag_q[ridx] == pc_q[31:IDX+2]);
    assign hit_data = data_q[ridx];
    // Every completed read fills the cache, even one whose data is dropped
    assign cwe = rdy & iMC_done & ((state_q == WAIT) | (state_q == DROP));

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (cwe) begin
            valid_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cwe) begin
            tag_q[widx]  <= miss_q[31:IDX+2];
            data_q[widx] <= iMC_inst;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = 32'h0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        miss_d  = miss_q;
        pv_d    = pv_q & ~oIQ_en;
        pinst_d = pinst_q;
        ppc_d   = ppc_q;
        mce_d   = mce_q;
        mca_d   = mca_q;
        if (rdy) begin
            if (iJUMP_en) begin
                pc_d = iJUMP_pc;
                pv_d = 1'b0;
                if (state_q == WAIT) begin
                    mce_d   = 1'b0;
                    state_d = iMC_done ? IDLE : DROP;
                end else if (state_q == DROP && iMC_done) begin
                    state_d = IDLE;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (slot_free) begin
                            if (hit) begin
                                pv_d    = 1'b1;
                                pinst_d = hit_data;
                                ppc_d   = pc_q;
                                pc_d    = pc_q + 32'd4;
                            end else begin
                                mce_d   = 1'b1;
                                mca_d   = pc_q;
                                miss_d  = pc_q;
                                state_d = WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (iMC_done) begin
                            pv_d    = 1'b1;
                            pinst_d = iMC_inst;
                            ppc_d   = miss_q;
                            pc_d    = miss_q + 32'd4;
                            mce_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                    DROP: begin
                        if (iMC_done) begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= 32'h0;
            miss_q  <= 32'h0;
            pv_q    <= 1'b0;
            pinst_q <= 32'h0;
            ppc_q   <= 32'h0;
            mce_q   <= 1'b0;
            mca_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            miss_q  <= miss_d;
            pv_q    <= pv_d;
            pinst_q <= pinst_d;
            ppc_q   <= ppc_d;
            mce_q   <= mce_d;
            mca_q   <= mca_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch; memory replies are driven by hand.
// The cache scenario is exercised only when ICACHE_EN is defined.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jen;
    logic [31:0] jpc;
    logic        full;
    logic        iq_en;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        mc_en;
    logic [31:0] mc_addr;
    logic        done;
    logic [31:0] minst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .iJUMP_en (jen),
        .iJUMP_pc (jpc),
        .iIQ_full (full),
        .oIQ_en   (iq_en),
        .oIQ_inst (iq_inst),
        .oIQ_pc   (iq_pc),
        .oMC_en   (mc_en),
        .oMC_addr (mc_addr),
        .iMC_done (done),
        .iMC_inst (minst)
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset;
        rst = 1; rdy = 1; jen = 0; jpc = 0;
        full = 0; done = 0; minst = 0;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        rst = 1; rdy = 1; jen = 0; jpc = 0;
        full = 0; done = 0; minst = 0;
        tick();
        tick();
        #1;
        total++;
        if (mc_en !== 1'b0) begin
            bad++; $display("FAIL rst_mc_en got %b want 0", mc_en);
        end
        total++;
        if (mc_addr !== 32'h0) begin
            bad++; $display("FAIL rst_mc_addr got %h want 0", mc_addr);
        end
        total++;
        if (iq_en !== 1'b0) begin
            bad++; $display("FAIL rst_iq_en got %b want 0", iq_en);
        end
        total++;
        if (iq_inst !== 32'h0 || iq_pc !== 32'h0) begin
            bad++;
            $display("FAIL rst_iq_data got %h/%h want 0/0", iq_inst, iq_pc);
        end
    endtask

    task automatic test_miss;
        apply_reset();
        tick();
        total++;
        if (mc_en !== 1'b1 || mc_addr !== 32'h0) begin
            bad++; $display("FAIL miss_req got %b/%h want 1/0", mc_en, mc_addr);
        end
        repeat (5) tick();
        total++;
        if (mc_en !== 1'b1 || mc_addr !== 32'h0 || iq_en !== 1'b0) begin
            bad++;
            $display("FAIL miss_hold got %b/%h/%b want 1/0/0", mc_en, mc_addr, iq_en);
        end
        done = 1; minst = 32'h0000_0013;
        tick();
        done = 0; minst = 0;
        #1;
        total++;
        if (iq_en !== 1'b1 || iq_pc !== 32'h0 || iq_inst !== 32'h13) begin
            bad++;
            $display("FAIL miss_push got %b/%h/%h want 1/0/13", iq_en, iq_pc, iq_inst);
        end
        total++;
        if (mc_en !== 1'b0) begin
            bad++; $display("FAIL miss_drop_en got %b want 0", mc_en);
        end
        tick();
        total++;
        if (iq_en !== 1'b0 || mc_en !== 1'b1 || mc_addr !== 32'h4) begin
            bad++;
            $display("FAIL miss_next got %b/%b/%h want 0/1/4", iq_en, mc_en, mc_addr);
        end
    endtask

    task automatic test_iq_full;
        apply_reset();
        tick();
        repeat (5) tick();
        done = 1; minst = 32'hA5A5_0001; full = 1;
        tick();
        done = 0; minst = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (iq_en !== 1'b0 || mc_en !== 1'b0) begin
                bad++;
                $display("FAIL full_hold cyc %0d got %b/%b want 0/0", i, iq_en, mc_en);
            end
            tick();
        end
        full = 0;
        #1;
        total++;
        if (iq_en !== 1'b1 || iq_pc !== 32'h0 || iq_inst !== 32'hA5A5_0001) begin
            bad++;
            $display("FAIL full_release got %b/%h/%h want 1/0/a5a50001", iq_en, iq_pc, iq_inst);
        end
        tick();
        total++;
        if (mc_en !== 1'b1 || mc_addr !== 32'h4) begin
            bad++; $display("FAIL full_next got %b/%h want 1/4", mc_en, mc_addr);
        end
    endtask

    task automatic test_drop;
        apply_reset();
        jen = 1; jpc = 32'h8;
        tick();
        jen = 0;
        #1;
        total++;
        if (mc_en !== 1'b0) begin
            bad++; $display("FAIL jump_nolookup got %b want 0", mc_en);
        end
        tick();
        total++;
        if (mc_en !== 1'b1 || mc_addr !== 32'h8) begin
            bad++; $display("FAIL drop_req got %b/%h want 1/8", mc_en, mc_addr);
        end
        tick();
        jen = 1; jpc = 32'h100;
        tick();
        jen = 0;
        #1;
        total++;
        if (mc_en !== 1'b0 || iq_en !== 1'b0) begin
            bad++; $display("FAIL drop_enter got %b/%b want 0/0", mc_en, iq_en);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (mc_en !== 1'b0 || iq_en !== 1'b0) begin
                bad++;
                $display("FAIL drop_wait cyc %0d got %b/%b want 0/0", i, mc_en, iq_en);
            end
        end
        done = 1; minst = 32'hDEAD_0008;
        tick();
        done = 0; minst = 0;
        #1;
        total++;
        if (iq_en !== 1'b0 || mc_en !== 1'b0) begin
            bad++; $display("FAIL drop_done got %b/%b want 0/0", iq_en, mc_en);
        end
        tick();
        total++;
        if (mc_en !== 1'b1 || mc_addr !== 32'h100 || iq_en !== 1'b0) begin
            bad++;
            $display("FAIL drop_target got %b/%h/%b want 1/100/0", mc_en, mc_addr, iq_en);
        end
        repeat (5) tick();
        done = 1; minst = 32'h0000_0100;
        tick();
        done = 0; minst = 0;
        #1;
        total++;
        if (iq_en !== 1'b1 || iq_pc !== 32'h100 || iq_inst !== 32'h100) begin
            bad++;
            $display("FAIL drop_push got %b/%h/%h want 1/100/100", iq_en, iq_pc, iq_inst);
        end
    endtask

    task automatic test_jump_done;
        apply_reset();
        tick();
        repeat (5) tick();
        done = 1; minst = 32'h13; jen = 1; jpc = 32'h40;
        #1;
        total++;
        if (iq_en !== 1'b0) begin
            bad++; $display("FAIL jd_same got %b want 0", iq_en);
        end
        tick();
        done = 0; minst = 0; jen = 0;
        #1;
        total++;
        if (iq_en !== 1'b0 || mc_en !== 1'b0) begin
            bad++; $display("FAIL jd_after got %b/%b want 0/0", iq_en, mc_en);
        end
        tick();
        total++;
        if (mc_en !== 1'b1 || mc_addr !== 32'h40) begin
            bad++; $display("FAIL jd_target got %b/%h want 1/40", mc_en, mc_addr);
        end
    endtask

    task automatic test_jump_push;
        apply_reset();
        tick();
        repeat (5) tick();
        done = 1; minst = 32'h77;
        tick();
        done = 0; minst = 0; jen = 1; jpc = 32'h200;
        #1;
        total++;
        if (iq_en !== 1'b0 || iq_inst !== 32'h0) begin
            bad++; $display("FAIL jp_block got %b/%h want 0/0", iq_en, iq_inst);
        end
        tick();
        jen = 0;
        #1;
        total++;
        if (iq_en !== 1'b0 || mc_en !== 1'b0) begin
            bad++; $display("FAIL jp_flush got %b/%b want 0/0", iq_en, mc_en);
        end
        tick();
        total++;
        if (mc_en !== 1'b1 || mc_addr !== 32'h200) begin
            bad++; $display("FAIL jp_target got %b/%h want 1/200", mc_en, mc_addr);
        end
    endtask

    task automatic test_rdy;
        apply_reset();
        tick();
        tick();
        rdy = 0;
        #1;
        total++;
        if (iq_en !== 1'b0 || mc_en !== 1'b1 || mc_addr !== 32'h0) begin
            bad++;
            $display("FAIL rdy_low got %b/%b/%h want 0/1/0", iq_en, mc_en, mc_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (iq_en !== 1'b0 || mc_en !== 1'b1 || mc_addr !== 32'h0) begin
                bad++;
                $display("FAIL rdy_hold cyc %0d got %b/%b/%h want 0/1/0", i, iq_en, mc_en, mc_addr);
            end
        end
        rdy = 1;
        tick();
        done = 1; minst = 32'h55;
        tick();
        done = 0; minst = 0;
        #1;
        total++;
        if (iq_en !== 1'b1 || iq_pc !== 32'h0 || iq_inst !== 32'h55) begin
            bad++;
            $display("FAIL rdy_resume got %b/%h/%h want 1/0/55", iq_en, iq_pc, iq_inst);
        end
        rdy = 0;
        #1;
        total++;
        if (iq_en !== 1'b0 || iq_inst !== 32'h0 || iq_pc !== 32'h0) begin
            bad++;
            $display("FAIL rdy_gate got %b/%h/%h want 0/0/0", iq_en, iq_inst, iq_pc);
        end
        tick();
        rdy = 1;
        #1;
        total++;
        if (iq_en !== 1'b1 || iq_pc !== 32'h0 || iq_inst !== 32'h55) begin
            bad++;
            $display("FAIL rdy_kept got %b/%h/%h want 1/0/55", iq_en, iq_pc, iq_inst);
        end
        tick();
        total++;
        if (mc_en !== 1'b1 || mc_addr !== 32'h4) begin
            bad++; $display("FAIL rdy_next got %b/%h want 1/4", mc_en, mc_addr);
        end
    endtask

    task automatic test_wrap;
        apply_reset();
        jen = 1; jpc = 32'hFFFF_FFFC;
        tick();
        jen = 0;
        tick();
        total++;
        if (mc_en !== 1'b1 || mc_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_req got %b/%h want 1/fffffffc", mc_en, mc_addr);
        end
        repeat (5) tick();
        done = 1; minst = 32'hAB;
        tick();
        done = 0; minst = 0;
        #1;
        total++;
        if (iq_en !== 1'b1 || iq_pc !== 32'hFFFF_FFFC || iq_inst !== 32'hAB) begin
            bad++;
            $display("FAIL wrap_push got %b/%h/%h want 1/fffffffc/ab", iq_en, iq_pc, iq_inst);
        end
        tick();
        total++;
        if (mc_en !== 1'b1 || mc_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_next got %b/%h want 1/0", mc_en, mc_addr);
        end
    endtask

`ifdef ICACHE_EN
    task automatic test_hit;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            tick();
            while (mc_en !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            total++;
            if (mc_en !== 1'b1 || mc_addr !== 32'(k * 4)) begin
                bad++;
                $display("FAIL hit_fill %0d got %b/%h want 1/%h", k, mc_en, mc_addr, 32'(k * 4));
            end
            repeat (4) tick();
            done = 1; minst = 32'h1000 + 32'(k);
            tick();
            done = 0; minst = 0;
        end
        jen = 1; jpc = 32'h0;
        tick();
        jen = 0;
        #1;
        total++;
        if (iq_en !== 1'b0 || mc_en !== 1'b0) begin
            bad++; $display("FAIL hit_redirect got %b/%b want 0/0", iq_en, mc_en);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            total++;
            if (iq_en !== 1'b1 || iq_pc !== 32'(j * 4) ||
                iq_inst !== 32'h1000 + 32'(j) || mc_en !== 1'b0) begin
                bad++;
                $display("FAIL hit_push %0d got %b/%h/%h/%b", j, iq_en, iq_pc, iq_inst, mc_en);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_miss();
        test_iq_full();
        test_drop();
        test_jump_done();
        test_jump_push();
        test_rdy();
        test_wrap();
`ifdef ICACHE_EN
        test_hit();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
